// File: rtl/sync_fifo_wm.sv
// sync_fifo_wm: synchronous FIFO of arbitrary depth with show-ahead read data.
// It also provides programmable almost-full/almost-empty watermarks, sticky
// overflow/underflow flags and a high-water-mark register.
// rst_n is an asynchronous, active-HIGH reset. The name is inherited from the
// existing codebase.
module sync_fifo_wm #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int W_LEVEL = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               wen,
  output logic [WIDTH-1:0]   rdata,
  input  logic               ren,
  input  logic               flush,
  input  logic [W_LEVEL-1:0] af_thresh,
  input  logic [W_LEVEL-1:0] ae_thresh,
  output logic               full,
  output logic               empty,
  output logic [W_LEVEL-1:0] level,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow,
  output logic [W_LEVEL-1:0] hwm
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [W_LEVEL-1:0] LVL_MAX  = W_LEVEL'(DEPTH);
  localparam logic [PW-1:0]      PTR_LAST = PW'(DEPTH - 1);

  // Storage is deliberately left without a reset so that it maps onto RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [W_LEVEL-1:0] level_q, level_d;
  logic [W_LEVEL-1:0] hwm_q, hwm_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               push_ok, pop_ok;

  // The depth need not be a power of two, so the pointer wraps explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Status flags are decoded from the level register. Threshold changes
  // therefore take effect in the same cycle.
  always_comb begin
    full         = (level_q == LVL_MAX);
    empty        = (level_q == '0);
    almost_full  = (level_q >= af_thresh);
    almost_empty = (level_q <= ae_thresh);
    level        = level_q;
    hwm          = hwm_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    rdata        = mem[rd_ptr_q];
  end

  // Accept decisions and next-state computation. Flush overrides everything.
  always_comb begin
    pop_ok      = 1'b0;
    push_ok     = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    hwm_d       = hwm_q;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      hwm_d       = '0;
    end else begin
      pop_ok  = ren && !empty;
      // A pop in the same cycle frees a slot, so a write to a full FIFO is legal.
      push_ok = wen && (!full || ren);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (wen && full && !ren) overflow_d  = 1'b1;
      if (ren && empty)        underflow_d = 1'b1;
      if (level_d > hwm_q)     hwm_d       = level_d;
    end
  end

  // Control state registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      hwm_q       <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      hwm_q       <= hwm_d;
    end
  end

  // Storage write port. Only accepted writes reach the array.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

`ifndef SYNTHESIS
  // Sanity checks on the occupancy counter while out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      assert (level_q <= LVL_MAX) else $error("level exceeds DEPTH");
      assert (!(full && empty)) else $error("full and empty both set");
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Directed testbench for sync_fifo_wm.
// DUT a has DEPTH=5 (not a power of two) and is used for data-path and flag
// scenarios. DUT b has DEPTH=8 and is used for watermark scenarios.
module tb_sync_fifo_wm;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  // DUT a: DEPTH 5, W_LEVEL 3
  logic [31:0] a_wdata, a_rdata;
  logic        a_wen, a_ren, a_flush;
  logic [2:0]  a_af, a_ae, a_level, a_hwm;
  logic        a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;

  // DUT b: DEPTH 8, W_LEVEL 4
  logic [31:0] b_wdata, b_rdata;
  logic        b_wen, b_ren, b_flush;
  logic [3:0]  b_af, b_ae, b_level, b_hwm;
  logic        b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;

  sync_fifo_wm #(.WIDTH(32), .DEPTH(5)) u_a (
    .clk(clk), .rst_n(rst), .wdata(a_wdata), .wen(a_wen), .rdata(a_rdata),
    .ren(a_ren), .flush(a_flush), .af_thresh(a_af), .ae_thresh(a_ae),
    .full(a_full), .empty(a_empty), .level(a_level), .almost_full(a_afull),
    .almost_empty(a_aempty), .overflow(a_ovf), .underflow(a_udf), .hwm(a_hwm)
  );

  sync_fifo_wm #(.WIDTH(32), .DEPTH(8)) u_b (
    .clk(clk), .rst_n(rst), .wdata(b_wdata), .wen(b_wen), .rdata(b_rdata),
    .ren(b_ren), .flush(b_flush), .af_thresh(b_af), .ae_thresh(b_ae),
    .full(b_full), .empty(b_empty), .level(b_level), .almost_full(b_afull),
    .almost_empty(b_aempty), .overflow(b_ovf), .underflow(b_udf), .hwm(b_hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive tasks: start 1 time unit after an edge, apply stimulus for one edge,
  // and return 1 time unit after that edge.
  task automatic a_cycle(input logic w, input logic r, input logic f, input logic [31:0] d);
    a_wen = w; a_ren = r; a_flush = f; a_wdata = d;
    @(posedge clk); #1;
    a_wen = 1'b0; a_ren = 1'b0; a_flush = 1'b0;
    $display("txn a: wen=%0b ren=%0b flush=%0b wdata=%h -> level=%0d rdata=%h", w, r, f, d, a_level, a_rdata);
  endtask

  task automatic b_cycle(input logic w, input logic r, input logic [31:0] d);
    b_wen = w; b_ren = r; b_wdata = d;
    @(posedge clk); #1;
    b_wen = 1'b0; b_ren = 1'b0;
    $display("txn b: wen=%0b ren=%0b wdata=%h -> level=%0d", w, r, d, b_level);
  endtask

  task automatic test_reset;
    rst = 1'b1; a_af = 3'd0; a_ae = 3'd1;
    #2;
    n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %0b want 1", a_empty); end
    n_cmp++; if (a_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b want 0", a_full); end
    n_cmp++; if (a_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", a_level); end
    n_cmp++; if ({a_ovf, a_udf} !== 2'b00) begin n_err++; $display("FAIL reset_errflags: got %b want 00", {a_ovf, a_udf}); end
    n_cmp++; if (a_hwm !== 3'd0) begin n_err++; $display("FAIL reset_hwm: got %0d want 0", a_hwm); end
    n_cmp++; if (a_afull !== 1'b1) begin n_err++; $display("FAIL reset_afull_thr0: got %0b want 1", a_afull); end
    n_cmp++; if (a_aempty !== 1'b1) begin n_err++; $display("FAIL reset_aempty: got %0b want 1", a_aempty); end
    a_af = 3'd4;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_order;
    a_cycle(1, 0, 0, 32'h11);
    n_cmp++; if (a_rdata !== 32'h11) begin n_err++; $display("FAIL basic_showahead: got %h want 00000011", a_rdata); end
    a_cycle(1, 0, 0, 32'h22);
    a_cycle(1, 0, 0, 32'h33);
    n_cmp++; if (a_level !== 3'd3) begin n_err++; $display("FAIL basic_level3: got %0d want 3", a_level); end
    n_cmp++; if (a_hwm !== 3'd3) begin n_err++; $display("FAIL basic_hwm3: got %0d want 3", a_hwm); end
    a_cycle(0, 1, 0, 32'h0);
    n_cmp++; if (a_rdata !== 32'h22) begin n_err++; $display("FAIL basic_head2: got %h want 00000022", a_rdata); end
    a_cycle(1, 1, 0, 32'h44);
    n_cmp++; if (a_level !== 3'd2) begin n_err++; $display("FAIL basic_rw_level: got %0d want 2", a_level); end
    n_cmp++; if (a_rdata !== 32'h33) begin n_err++; $display("FAIL basic_head3: got %h want 00000033", a_rdata); end
    a_cycle(0, 1, 0, 32'h0);
    n_cmp++; if (a_rdata !== 32'h44) begin n_err++; $display("FAIL basic_head4: got %h want 00000044", a_rdata); end
    a_cycle(0, 1, 0, 32'h0);
    n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL basic_drained: got %0b want 1", a_empty); end
    n_cmp++; if ({a_ovf, a_udf} !== 2'b00) begin n_err++; $display("FAIL basic_errflags: got %b want 00", {a_ovf, a_udf}); end
  endtask

  task automatic test_full_boundary;
    for (int i = 0; i < 5; i++) a_cycle(1, 0, 0, 32'hA0 + i);
    n_cmp++; if (a_full !== 1'b1 || a_level !== 3'd5) begin n_err++; $display("FAIL full_flag: got full=%0b level=%0d want 1/5", a_full, a_level); end
    n_cmp++; if (a_hwm !== 3'd5) begin n_err++; $display("FAIL full_hwm: got %0d want 5", a_hwm); end
    n_cmp++; if (a_afull !== 1'b1) begin n_err++; $display("FAIL full_afull: got %0b want 1", a_afull); end
    a_cycle(1, 0, 0, 32'hFF);
    n_cmp++; if (a_ovf !== 1'b1 || a_level !== 3'd5) begin n_err++; $display("FAIL full_overflow: got ovf=%0b level=%0d want 1/5", a_ovf, a_level); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (a_rdata !== 32'hA0 + i) begin n_err++; $display("FAIL full_order%0d: got %h want %h", i, a_rdata, 32'hA0 + i); end
      a_cycle(0, 1, 0, 32'h0);
    end
    n_cmp++; if (a_empty !== 1'b1 || a_ovf !== 1'b1) begin n_err++; $display("FAIL full_sticky: got empty=%0b ovf=%0b want 1/1", a_empty, a_ovf); end
    a_cycle(0, 0, 1, 32'h0);
    n_cmp++; if (a_ovf !== 1'b0 || a_hwm !== 3'd0) begin n_err++; $display("FAIL full_flushclr: got ovf=%0b hwm=%0d want 0/0", a_ovf, a_hwm); end
  endtask

  task automatic test_simul_full;
    logic [31:0] exp [5];
    exp[0] = 32'hC1; exp[1] = 32'hC2; exp[2] = 32'hC3; exp[3] = 32'hC4; exp[4] = 32'hA5A5A5A5;
    for (int i = 0; i < 5; i++) a_cycle(1, 0, 0, 32'hC0 + i);
    a_cycle(1, 1, 0, 32'hA5A5A5A5);
    n_cmp++; if (a_level !== 3'd5 || a_full !== 1'b1) begin n_err++; $display("FAIL simfull_level: got level=%0d full=%0b want 5/1", a_level, a_full); end
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL simfull_ovf: got %0b want 0", a_ovf); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (a_rdata !== exp[i]) begin n_err++; $display("FAIL simfull_order%0d: got %h want %h", i, a_rdata, exp[i]); end
      a_cycle(0, 1, 0, 32'h0);
    end
    n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL simfull_drained: got %0b want 1", a_empty); end
  endtask

  task automatic test_empty_corner;
    a_cycle(1, 1, 0, 32'h12345678);
    n_cmp++; if (a_level !== 3'd1) begin n_err++; $display("FAIL ecorner_level: got %0d want 1", a_level); end
    n_cmp++; if (a_udf !== 1'b1) begin n_err++; $display("FAIL ecorner_udf: got %0b want 1", a_udf); end
    n_cmp++; if (a_rdata !== 32'h12345678) begin n_err++; $display("FAIL ecorner_rdata: got %h want 12345678", a_rdata); end
    a_cycle(0, 1, 0, 32'h0);
    n_cmp++; if (a_empty !== 1'b1 || a_udf !== 1'b1) begin n_err++; $display("FAIL ecorner_after: got empty=%0b udf=%0b want 1/1", a_empty, a_udf); end
    a_cycle(0, 0, 1, 32'h0);
  endtask

  task automatic test_watermarks;
    b_af = 4'd6; b_ae = 4'd2;
    for (int i = 0; i <= 8; i++) begin
      n_cmp++; if (b_aempty !== (i <= 2)) begin n_err++; $display("FAIL wm_aempty_l%0d: got %0b want %0b", i, b_aempty, (i <= 2)); end
      n_cmp++; if (b_afull !== (i >= 6)) begin n_err++; $display("FAIL wm_afull_l%0d: got %0b want %0b", i, b_afull, (i >= 6)); end
      if (i < 8) b_cycle(1, 0, 32'h100 + i);
    end
    for (int i = 0; i < 4; i++) b_cycle(0, 1, 32'h0);
    n_cmp++; if (b_level !== 4'd4 || b_afull !== 1'b0) begin n_err++; $display("FAIL wm_l4: got level=%0d afull=%0b want 4/0", b_level, b_afull); end
    b_af = 4'd3; #1;
    n_cmp++; if (b_afull !== 1'b1) begin n_err++; $display("FAIL wm_thr_change: got %0b want 1", b_afull); end
    b_af = 4'd9; #1;
    n_cmp++; if (b_afull !== 1'b0) begin n_err++; $display("FAIL wm_af_over_depth: got %0b want 0", b_afull); end
    b_ae = 4'd8; #1;
    n_cmp++; if (b_aempty !== 1'b1) begin n_err++; $display("FAIL wm_ae_depth: got %0b want 1", b_aempty); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_reset;
    for (int i = 0; i < 5; i++) a_cycle(1, 0, 0, 32'hD0 + i);
    a_cycle(1, 0, 0, 32'hEE);
    a_cycle(0, 1, 0, 32'h0);
    a_cycle(0, 1, 0, 32'h0);
    n_cmp++; if (a_level !== 3'd3 || a_ovf !== 1'b1 || a_hwm !== 3'd5) begin n_err++; $display("FAIL flush_pre: got level=%0d ovf=%0b hwm=%0d want 3/1/5", a_level, a_ovf, a_hwm); end
    a_cycle(1, 1, 1, 32'hBAD);
    n_cmp++; if (a_level !== 3'd0 || a_empty !== 1'b1) begin n_err++; $display("FAIL flush_level: got level=%0d empty=%0b want 0/1", a_level, a_empty); end
    n_cmp++; if ({a_ovf, a_udf} !== 2'b00 || a_hwm !== 3'd0) begin n_err++; $display("FAIL flush_flags: got ovf/udf=%b hwm=%0d want 00/0", {a_ovf, a_udf}, a_hwm); end
    a_cycle(1, 0, 0, 32'h55);
    n_cmp++; if (a_rdata !== 32'h55 || a_level !== 3'd1) begin n_err++; $display("FAIL flush_postwrite: got rdata=%h level=%0d want 00000055/1", a_rdata, a_level); end
    a_cycle(1, 0, 0, 32'h66);
    a_wen = 1'b1; a_wdata = 32'h77;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    n_cmp++; if (a_level !== 3'd0 || a_empty !== 1'b1 || a_full !== 1'b0) begin n_err++; $display("FAIL async_rst_level: got level=%0d empty=%0b full=%0b want 0/1/0", a_level, a_empty, a_full); end
    n_cmp++; if (a_hwm !== 3'd0 || a_aempty !== 1'b1) begin n_err++; $display("FAIL async_rst_hwm: got hwm=%0d aempty=%0b want 0/1", a_hwm, a_aempty); end
    a_wen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (a_empty !== 1'b1 || {a_ovf, a_udf} !== 2'b00) begin n_err++; $display("FAIL post_rst: got empty=%0b ovf/udf=%b want 1/00", a_empty, {a_ovf, a_udf}); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    a_wen = 0; a_ren = 0; a_flush = 0; a_wdata = '0;
    b_wen = 0; b_ren = 0; b_flush = 0; b_wdata = '0; b_af = 4'd6; b_ae = 4'd2;
    test_reset;
    test_basic_order;
    test_full_boundary;
    test_simul_full;
    test_empty_corner;
    test_watermarks;
    test_flush_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_wm.md
Name: sync_fifo_wm

Overview:
Parametrised synchronous FIFO, successor to the basic sync_fifo. Adds arbitrary (non-power-of-2) depth, programmable almost-full/almost-empty watermarks, sticky overflow/underflow error flags and a high-water-mark tracker. Used between bus masters and peripherals (UART, audio, DMA) where software tunes interrupt thresholds at run time.

Parameters:
WIDTH, 32, data width in bits (>= 1)
DEPTH, 4, number of entries (>= 2, any integer, not restricted to powers of 2)
W_LEVEL, $clog2(DEPTH+1), width of level/threshold/hwm fields (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-high
wdata  input  WIDTH  write data
wen  input  1  write enable, sampled on posedge clk
rdata  output  WIDTH  show-ahead head-of-queue data
ren  input  1  read enable (pop), sampled on posedge clk
flush  input  1  synchronous clear
af_thresh  input  W_LEVEL  almost-full threshold
ae_thresh  input  W_LEVEL  almost-empty threshold
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  W_LEVEL  current occupancy
almost_full  output  1  level >= af_thresh
almost_empty  output  1  level <= ae_thresh
overflow  output  1  sticky: write attempted while full with no same-cycle pop
underflow  output  1  sticky: read attempted while empty
hwm  output  W_LEVEL  maximum level reached since reset/flush

Behaviour:
- Reset (rst_n=1, async): pointers, level, overflow, underflow, hwm -> 0; empty=1, full=0, almost_empty=1, almost_full=(af_thresh==0). Storage array not reset.
- rdata: combinational from mem[rd_ptr]; valid whenever empty=0; don't-care when empty. Zero-cycle show-ahead: data written at edge N is visible on rdata after edge N if FIFO was empty.
- Pointers: rd_ptr/wr_ptr, range 0..DEPTH-1; increment wraps DEPTH-1 -> 0 explicitly (no reliance on binary wrap).
- level is a registered counter: +1 on accepted write only, -1 on accepted pop only, unchanged when both or neither.
- Accept rules per cycle (flush=0):
  - pop accepted iff ren && !empty.
  - write accepted iff wen && (!full || ren). Full + wen + ren: both happen, level stays DEPTH.
  - Empty + wen + ren: write accepted, pop rejected, underflow set; level -> 1.
  - wen && full && !ren: write dropped, contents untouched, overflow set.
  - ren && empty: no pointer change, underflow set.
- overflow/underflow: sticky, cleared only by reset or flush.
- flush: highest priority. Next cycle: pointers=0, level=0, overflow=0, underflow=0, hwm=0. Same-cycle wen/ren ignored and never flag errors.
- hwm: register updated to next-level value when next-level > hwm; tracks post-edge level, so hwm==DEPTH after first fill.
- full/empty/almost_*: combinational from level register and threshold inputs; thresholds may change any cycle and take effect immediately. af_thresh > DEPTH -> almost_full never asserts; ae_thresh >= DEPTH -> almost_empty always asserts.
- Simulation-only assertions: level <= DEPTH; full and empty never both 1.

Test Plan:
- Basic order: DEPTH=4, 1000 random words with random gaps on both sides -> rdata matches write order, overflow=underflow=0, hwm<=4.
- Full boundary: DEPTH=5 (non-pow2), write 5 words -> full=1, level=5; 6th write with ren=0 -> dropped, overflow=1; next 5 pops return first 5 words, pointers wrap correctly on further traffic.
- Simultaneous full: fill DEPTH=4, assert wen+ren one cycle with 0xA5A5A5A5 -> level stays 4, overflow=0, word appears 4th in read order.
- Empty corner: empty FIFO, wen+ren with 0x12345678 -> level=1, underflow=1, rdata=0x12345678 next cycle.
- Watermarks: DEPTH=8, af_thresh=6, ae_thresh=2 -> almost_empty for levels 0..2, almost_full for 6..8; change af_thresh to 3 at level 4 -> almost_full=1 same cycle.
- Flush/reset: at level 3 with overflow=1, hwm=4, pulse flush with wen=1 -> next cycle level=0, empty=1, overflow=0, hwm=0, write discarded; assert rst_n=1 mid-traffic -> all outputs at reset values immediately (async).
